// File: rtl/pht_counter_table.sv
// Pattern history table of saturating branch counters with a post-reset/flush init sweep.
// Define PHT_GSHARE_EN for gshare indexing (address XOR global history); default is bimodal.
module pht_counter_table #(
    parameter int s_index    = 6,
    parameter int width      = 2,
    parameter int init_value = 2**(width-1)-1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [s_index-1:0] pred_addr,
    output logic               pred_taken,
    output logic [width-1:0]   pred_counter,
    output logic [s_index-1:0] pred_hist,
    output logic               ready,
    input  logic               upd_valid,
    input  logic [s_index-1:0] upd_addr,
    input  logic [s_index-1:0] upd_hist,
    input  logic               upd_taken
);

    localparam int num_sets = 2**s_index;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [s_index-1:0] last_idx = '1;
    localparam logic [width-1:0]   cnt_max  = '1;
    localparam logic [width-1:0]   cnt_min  = '0;
    localparam logic [width-1:0]   init_cnt = init_value[width-1:0];

    logic [0:0]         state;
    logic [s_index-1:0] sweep_ptr;
    logic [width-1:0]   tbl [num_sets];

    logic [s_index-1:0] pidx;
    logic [s_index-1:0] uidx;
    logic               upd_en;
    logic [width-1:0]   upd_cur;
    logic [width-1:0]   upd_next;

    assign ready  = (state == ST_READY);
    assign upd_en = ready && upd_valid && !flush;

    // Sweep sequencer: one entry per cycle, flush restarts it from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else if (flush) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else if (state == ST_INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == last_idx)
                state <= ST_READY;
        end
    end

`ifdef PHT_GSHARE_EN
    logic [s_index-1:0] ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (flush)
            ghr <= '0;
        else if (upd_en)
            ghr <= {ghr[s_index-2:0], upd_taken};
    end

    assign pidx      = pred_addr ^ ghr;
    assign uidx      = upd_addr ^ upd_hist;
    assign pred_hist = ghr;
`else
    logic unused_hist;

    assign pidx        = pred_addr;
    assign uidx        = upd_addr;
    assign pred_hist   = '0;
    assign unused_hist = ^upd_hist;
`endif

    assign upd_cur = tbl[uidx];

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != cnt_max)
                upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != cnt_min)
                upd_next = upd_cur - 1'b1;
        end
    end

    // Table storage is deliberately unreset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            tbl[sweep_ptr] <= init_cnt;
        else if (upd_en)
            tbl[uidx] <= upd_next;
    end

    // Read side shows the stored value only; an update in the same cycle lands after the edge.
    assign pred_counter = ready ? tbl[pidx] : '0;
    assign pred_taken   = pred_counter[width-1];

endmodule
